// File: rtl/piso_tx_pkg.sv
// Shared types and default sizing for the parallel-in/serial-out transmitter.
package piso_tx_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_DIV_BITS = 25;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Bit-period divider: free-running up-counter that pulses tick on its terminal count.
module tick_gen #(
    parameter int DIV_BITS = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [DIV_BITS-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Gated by en so a stale count can never fire a tick outside a frame.
    assign tick = en && (r_count == {DIV_BITS{1'b1}});

endmodule

// File: rtl/piso_tx.sv
// Serializes a WIDTH-bit word MSB first, holding each bit for 2^DIV_BITS clocks.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DIV_BITS = DEF_DIV_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_bitCnt;
    logic             w_accept;
    logic             w_tick;
    logic             w_lastBit;

    assign w_accept  = load && (r_state == IDLE);
    assign w_lastBit = (r_bitCnt == CNT_W'(WIDTH - 1));

    tick_gen #(
        .DIV_BITS (DIV_BITS)
    ) u_tickGen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accept),
        .en   (r_state == SHIFT),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (load) w_nextState = SHIFT;
            SHIFT:   if (w_tick && w_lastBit) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The final tick leaves the shifter untouched; sout is masked by state instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
        end else if (w_accept) begin
            r_shift  <= din;
            r_bitCnt <= '0;
        end else if (r_state == SHIFT && w_tick && !w_lastBit) begin
            r_shift  <= r_shift << 1;
            r_bitCnt <= r_bitCnt + 1'b1;
        end
    end

    always_comb begin
        ready = (r_state == IDLE);
        busy  = (r_state == SHIFT);
        sout  = (r_state == SHIFT) && r_shift[WIDTH-1];
        done  = (r_state == SHIFT) && w_tick && w_lastBit;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, frame length in bits.
REQ-002 Parameter DIV_BITS, default 25, bit period P = 2^DIV_BITS clk cycles; benches use 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 load  input  1  request to start a frame with din.
REQ-007 ready  output  1  high when a load will be accepted.
REQ-008 sout  output  1  serial data, MSB first, feeds the 4-bit SIPO receiver's serial input.
REQ-009 busy  output  1  high while a frame is being shifted.
REQ-010 done  output  1  one-cycle pulse at frame end.

Function
REQ-011 FSM states: IDLE, SHIFT; ready = (state==IDLE); busy = (state==SHIFT).
REQ-012 Load acceptance: load=1 and ready=1 at edge t -> shift register <= din, bit counter <= 0, divider cleared, state <= SHIFT.
REQ-013 sout = shift register MSB while in SHIFT; sout = 0 in IDLE.
REQ-014 First bit (din[WIDTH-1]) appears on sout at cycle t+1.
REQ-015 Divider: DIV_BITS-bit up-counter, wraps modulo 2^DIV_BITS, runs only in SHIFT, cleared on load acceptance.
REQ-016 tick = 1 for exactly one cycle when counter == 2^DIV_BITS-1; first tick at cycle t+P.
REQ-017 Each bit is held on sout for exactly P cycles.
REQ-018 Tick in SHIFT with bit counter < WIDTH-1: shift register left by one, zero fill, bit counter +1.
REQ-019 Tick in SHIFT with bit counter == WIDTH-1: state <= IDLE, done = 1 for one cycle, sout returns to 0.
REQ-020 done is asserted at cycle t+WIDTH*P and deasserted the following cycle.
REQ-021 load while busy is ignored; din changes during SHIFT do not affect sout.
REQ-022 load in the same cycle as the final tick is ignored (ready=0); a load the next cycle is accepted.
REQ-023 A load held high in IDLE starts back-to-back frames with one idle cycle (sout=0) between frames.
REQ-024 After WIDTH ticks, a 4-bit SIPO receiver clocked by the same tick holds out == din.

Reset
REQ-025 rst=1 at an edge -> state IDLE, shift register 0, bit counter 0, divider 0.
REQ-026 Reset output values: sout=0, busy=0, done=0, ready=1 from the cycle after rst is sampled.
REQ-027 rst mid-frame aborts the frame with no done pulse; rst has priority over load and tick.

Structure
REQ-028 A shared package holds the FSM state enum and the default WIDTH and DIV_BITS constants.
REQ-029 Divider is a sub-module tick_gen (clk, rst, clr, en -> tick).
REQ-030 All outputs are registered or decoded from registered state only; no latches.

Verification (DIV_BITS=2, P=4, WIDTH=4)
REQ-031 Reset check: rst for 2 cycles -> sout=0, busy=0, done=0, ready=1.
REQ-032 Single frame: load din=4'b1011 at edge t -> sout 1,0,1,1 for 4 cycles each from t+1; done at t+16; loopback SIPO out=4'b1011.
REQ-033 Ignored load: load din=4'b0110, then load din=4'b1111 at t+5 -> serial stream is still 0,1,1,0.
REQ-034 Collision: load held high continuously with din=4'b1001 -> done at t+16, next frame accepted at t+17, idle sout=0 in between.
REQ-035 Reset abort: rst at t+6 mid-frame -> no done pulse, sout=0, ready=1 on the next cycle.
REQ-036 Corner words: din=4'b0000 -> sout stays 0 and done pulses; din=4'b1111 -> sout=1 for 16 cycles, then 0.
